// File: rtl/omem_ahb_writer_if.sv
// omem_ahb_writer_if: packer, controller and AHB-Lite signals
// for the output-memory write-back stage.
interface omem_ahb_writer_if;
  logic        I_OWR_START;
  logic [31:0] I_OWR_BASE_ADDR;
  logic [15:0] I_OWR_WORD_COUNT;
  logic [31:0] I_OWR_WDATA;
  logic        I_OWR_WVALID;
  logic        O_OWR_WREADY;
  logic [31:0] O_OWR_HADDR;
  logic [1:0]  O_OWR_HTRANS;
  logic        O_OWR_HWRITE;
  logic [2:0]  O_OWR_HSIZE;
  logic [2:0]  O_OWR_HBURST;
  logic [31:0] O_OWR_HWDATA;
  logic        I_OWR_HREADY;
  logic        I_OWR_HRESP;
  logic        O_OWR_BUSY;
  logic        O_OWR_DONE;
  logic        O_OWR_ERROR;

  modport master (
    input  I_OWR_START, I_OWR_BASE_ADDR, I_OWR_WORD_COUNT,
    input  I_OWR_WDATA, I_OWR_WVALID,
    input  I_OWR_HREADY, I_OWR_HRESP,
    output O_OWR_WREADY, O_OWR_HADDR, O_OWR_HTRANS,
    output O_OWR_HWRITE, O_OWR_HSIZE, O_OWR_HBURST,
    output O_OWR_HWDATA, O_OWR_BUSY, O_OWR_DONE,
    output O_OWR_ERROR
  );

  modport slave (
    output I_OWR_START, I_OWR_BASE_ADDR, I_OWR_WORD_COUNT,
    output I_OWR_WDATA, I_OWR_WVALID,
    output I_OWR_HREADY, I_OWR_HRESP,
    input  O_OWR_WREADY, O_OWR_HADDR, O_OWR_HTRANS,
    input  O_OWR_HWRITE, O_OWR_HSIZE, O_OWR_HBURST,
    input  O_OWR_HWDATA, O_OWR_BUSY, O_OWR_DONE,
    input  O_OWR_ERROR
  );
endinterface

// File: rtl/omem_ahb_writer.sv
// omem_ahb_writer: buffers packed pixel words in a FIFO and
// writes them as single AHB-Lite word transfers.
module omem_ahb_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input logic              I_OWR_HCLK,
  input logic              I_OWR_HRESET,
  omem_ahb_writer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_FIN, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [31:0]     haddr_q, haddr_d;
  logic [15:0]     rem_q, rem_d;
  logic            error_q, error_d;
  logic            full, empty;
  logic            push, pop, flush;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign flush = (state_q == S_ERR);
  assign pop   = (state_q == S_DATA) && bus.I_OWR_HREADY &&
                 !bus.I_OWR_HRESP;
  assign push  = bus.I_OWR_WVALID && !full && !flush;

  // FIFO pointers and occupancy; a flush drops any same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push}
                    - {{AW{1'b0}}, pop};
    end
  end

  // job sequencing: address phase, data phase, completion
  always_comb begin
    state_d = state_q;
    haddr_d = haddr_q;
    rem_d   = rem_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.I_OWR_START) begin
          haddr_d = {bus.I_OWR_BASE_ADDR[31:2], 2'b00};
          rem_d   = bus.I_OWR_WORD_COUNT;
          error_d = 1'b0;
          state_d = (bus.I_OWR_WORD_COUNT == '0) ?
                    S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        if (!empty && bus.I_OWR_HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.I_OWR_HREADY) begin
          if (bus.I_OWR_HRESP) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            haddr_d = haddr_q + 32'd4;
            if (rem_q != '0) rem_d = rem_q - 16'd1;
            state_d = (rem_q <= 16'd1) ? S_FIN : S_ADDR;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // control and FIFO bookkeeping registers
  always_ff @(posedge I_OWR_HCLK or posedge I_OWR_HRESET) begin
    if (I_OWR_HRESET) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      haddr_q  <= '0;
      rem_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      haddr_q  <= haddr_d;
      rem_q    <= rem_d;
      error_q  <= error_d;
    end
  end

  // FIFO storage; contents are only read while non-empty
  always_ff @(posedge I_OWR_HCLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.I_OWR_WDATA;
  end

  assign bus.O_OWR_WREADY = !full;
  assign bus.O_OWR_HADDR  = haddr_q;
  assign bus.O_OWR_HTRANS = (state_q == S_ADDR && !empty) ?
                            2'b10 : 2'b00;
  assign bus.O_OWR_HWDATA = (state_q == S_DATA) ?
                            mem_q[rd_ptr_q] : '0;
  assign bus.O_OWR_HWRITE = 1'b1;
  assign bus.O_OWR_HSIZE  = 3'b010;
  assign bus.O_OWR_HBURST = 3'b000;
  assign bus.O_OWR_BUSY   = (state_q == S_ADDR) ||
                            (state_q == S_DATA);
  assign bus.O_OWR_DONE   = (state_q == S_FIN) ||
                            (state_q == S_ERR);
  assign bus.O_OWR_ERROR  = error_q;
endmodule

// File: tb/tb_omem_ahb_writer.sv
// tb_omem_ahb_writer: directed and random jobs scored against a
// queue-based model of the write-back stage.
module tb_omem_ahb_writer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  omem_ahb_writer_if bus();

  omem_ahb_writer #(.FIFO_DEPTH(DEPTH)) dut (
    .I_OWR_HCLK  (clk),
    .I_OWR_HRESET(rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] src[$];
  logic        hr_q[$];
  logic        hs_q[$];
  logic        rnd_hr = 1'b0;
  logic        rnd_wv = 1'b0;
  int          done_cyc = -1;

  logic [31:0] mq[$];
  int          mphase = 0;
  logic        merr = 1'b0;
  logic        mflush = 1'b0;
  logic        in_data = 1'b0;
  logic [31:0] maddr = '0;
  int          mrem = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic observe();
    logic acc;
    int   nphase;
    if (bus.O_OWR_DONE) done_cyc = cyc;
    if (rst) begin
      chk("rst_haddr", bus.O_OWR_HADDR, 32'h0);
      chk("rst_htrans", 32'(bus.O_OWR_HTRANS), 32'h0);
      chk("rst_hwdata", bus.O_OWR_HWDATA, 32'h0);
      chk("rst_wready", 32'(bus.O_OWR_WREADY), 32'h1);
      chk("rst_busy", 32'(bus.O_OWR_BUSY), 32'h0);
      chk("rst_done", 32'(bus.O_OWR_DONE), 32'h0);
      chk("rst_error", 32'(bus.O_OWR_ERROR), 32'h0);
      mq.delete();
      mphase  = 0;
      merr    = 1'b0;
      mflush  = 1'b0;
      in_data = 1'b0;
      return;
    end
    nphase = mphase;
    acc = bus.I_OWR_WVALID && (mq.size() < DEPTH);
    chk("wready", 32'(bus.O_OWR_WREADY),
        32'(mq.size() < DEPTH));
    chk("done", 32'(bus.O_OWR_DONE), 32'(mphase == 2));
    chk("busy", 32'(bus.O_OWR_BUSY), 32'(mphase == 1));
    chk("error", 32'(bus.O_OWR_ERROR), 32'(merr));
    chk("const", {25'd0, bus.O_OWR_HWRITE, bus.O_OWR_HSIZE,
                  bus.O_OWR_HBURST}, 32'h50);
    if (mphase == 1 && in_data) begin
      chk("dp_htrans", 32'(bus.O_OWR_HTRANS), 32'h0);
      chk("dp_haddr", bus.O_OWR_HADDR, maddr);
      if (mq.size() > 0)
        chk("hwdata", bus.O_OWR_HWDATA, mq[0]);
      else
        chk("dp_nodata", 32'(mq.size()), 32'h1);
      if (bus.I_OWR_HREADY) begin
        in_data = 1'b0;
        if (bus.I_OWR_HRESP) begin
          merr   = 1'b1;
          mflush = 1'b1;
          nphase = 2;
        end else begin
          if (mq.size() > 0) mq.delete(0);
          maddr = maddr + 32'd4;
          mrem--;
          if (mrem == 0) nphase = 2;
        end
      end
    end else if (mphase == 1) begin
      chk("ap_htrans", 32'(bus.O_OWR_HTRANS),
          (mq.size() > 0) ? 32'h2 : 32'h0);
      if (mq.size() > 0) begin
        chk("ap_haddr", bus.O_OWR_HADDR, maddr);
        if (bus.I_OWR_HREADY) in_data = 1'b1;
      end
    end else begin
      chk("idle_htrans", 32'(bus.O_OWR_HTRANS), 32'h0);
    end
    if (mphase == 2) begin
      nphase = 0;
      if (mflush) begin
        mq.delete();
        acc    = 1'b0;
        mflush = 1'b0;
      end
    end
    if (mphase == 0 && bus.I_OWR_START) begin
      merr   = 1'b0;
      maddr  = bus.I_OWR_BASE_ADDR & 32'hFFFF_FFFC;
      mrem   = int'(bus.I_OWR_WORD_COUNT);
      nphase = (mrem == 0) ? 2 : 1;
    end
    if (acc) mq.push_back(bus.I_OWR_WDATA);
    mphase = nphase;
  endtask

  task automatic step(input logic st = 1'b0,
                      input logic [31:0] b = 32'h0,
                      input logic [15:0] n = 16'h0);
    logic        acc;
    logic [31:0] tmp;
    @(negedge clk);
    observe();
    acc = bus.I_OWR_WVALID && bus.O_OWR_WREADY;
    @(posedge clk);
    #1;
    if (acc && src.size() > 0) tmp = src.pop_front();
    bus.I_OWR_START      = st;
    bus.I_OWR_BASE_ADDR  = b;
    bus.I_OWR_WORD_COUNT = n;
    if (hr_q.size() > 0) bus.I_OWR_HREADY = hr_q.pop_front();
    else if (rnd_hr) bus.I_OWR_HREADY = ($urandom_range(0, 3) != 0);
    else bus.I_OWR_HREADY = 1'b1;
    if (hs_q.size() > 0) bus.I_OWR_HRESP = hs_q.pop_front();
    else bus.I_OWR_HRESP = 1'b0;
    if (src.size() > 0 && (!rnd_wv || $urandom_range(0, 1) == 1)) begin
      bus.I_OWR_WVALID = 1'b1;
      bus.I_OWR_WDATA  = src[0];
    end else begin
      bus.I_OWR_WVALID = 1'b0;
      bus.I_OWR_WDATA  = $urandom;
    end
  endtask

  task automatic run_job(input string tag, input logic [31:0] b,
                         input logic [15:0] n, input int lat);
    int t0;
    step(1'b1, b, n);
    t0 = cyc;
    done_cyc = -1;
    for (int i = 0; i < 600 && done_cyc < 0; i++) step();
    if (lat >= 0) chk(tag, 32'(done_cyc - t0), 32'(lat));
    else chk(tag, 32'(done_cyc >= 0), 32'h1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    bus.I_OWR_START      = 1'b0;
    bus.I_OWR_BASE_ADDR  = '0;
    bus.I_OWR_WORD_COUNT = '0;
    bus.I_OWR_WDATA      = '0;
    bus.I_OWR_WVALID     = 1'b0;
    bus.I_OWR_HREADY     = 1'b1;
    bus.I_OWR_HRESP      = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);

    src.push_back(32'h11223344);
    src.push_back(32'h55667788);
    src.push_back(32'h99AABBCC);
    idle(5);
    run_job("basic_done", 32'h1000, 16'd3, 7);
    idle(2);

    src.push_back($urandom);
    src.push_back($urandom);
    src.push_back($urandom);
    idle(5);
    hr_q = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_job("wait_done", 32'h2000, 16'd3, 9);
    idle(2);

    for (int i = 0; i < 6; i++) src.push_back(32'hA000_0000 + i);
    idle(8);
    chk("wready_full", 32'(bus.O_OWR_WREADY), 32'h0);
    run_job("deep_done", 32'h3000, 16'd6, 13);
    idle(2);

    for (int i = 0; i < 3; i++) src.push_back($urandom);
    idle(5);
    run_job("wrap_done", 32'hFFFF_FFF8, 16'd3, 7);
    idle(2);

    for (int i = 0; i < 4; i++) src.push_back($urandom);
    idle(6);
    hs_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_job("err_done", 32'h4000, 16'd4, 5);
    chk("err_flag", 32'(bus.O_OWR_ERROR), 32'h1);
    chk("err_empty", 32'(mq.size()), 32'h0);
    idle(3);
    run_job("cnt0_done", 32'h5000, 16'd0, 1);
    chk("err_clear", 32'(bus.O_OWR_ERROR), 32'h0);
    idle(2);

    rnd_hr = 1'b1;
    rnd_wv = 1'b1;
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) src.push_back($urandom);
      run_job("rand_done", $urandom, 16'(n), -1);
      idle($urandom_range(0, 3));
    end
    rnd_hr = 1'b0;
    rnd_wv = 1'b0;
    idle(2);

    for (int i = 0; i < 3; i++) src.push_back($urandom);
    idle(5);
    step(1'b1, 32'h6000, 16'd5);
    idle(2);
    rst = 1'b1;
    src.delete();
    bus.I_OWR_WVALID = 1'b0;
    done_cyc = -1;
    idle(2);
    chk("rst_nodone", 32'(done_cyc), 32'hFFFF_FFFF);
    rst = 1'b0;
    idle(2);
    src.push_back($urandom);
    src.push_back($urandom);
    idle(4);
    run_job("post_rst", 32'h7004, 16'd2, 5);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/omem_ahb_writer.md
# omem_ahb_writer

Downstream write-back stage for the rotate engine's output memory. Accepts packed 32-bit pixel words (four bytes, byte 0 in bits [7:0]) from the output-memory packer, buffers them in a small FIFO, and writes them to system memory as single AHB-Lite write transfers at consecutive word addresses. A job is armed by a start pulse carrying base address and word count; completion or bus error is reported to the controller.

## Interface
- FIFO_DEPTH, 4, input word FIFO entries; power of two, ≥2
- I_OWR_HCLK  in  1  AHB clock; all logic on rising edge
- I_OWR_HRESET  in  1  asynchronous, active-high reset
- I_OWR_START  in  1  one-cycle job start; sampled only in IDLE
- I_OWR_BASE_ADDR  in  32  first write address, captured on accepted START; bits [1:0] forced to 0
- I_OWR_WORD_COUNT  in  16  number of words in job, captured on accepted START
- I_OWR_WDATA  in  32  packed pixel word from packer
- I_OWR_WVALID  in  1  WDATA valid
- O_OWR_WREADY  out  1  FIFO not full; word accepted when WVALID && WREADY
- O_OWR_HADDR  out  32  AHB address
- O_OWR_HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE only
- O_OWR_HWRITE  out  1  constant 1
- O_OWR_HSIZE  out  3  constant 3'b010 (word)
- O_OWR_HBURST  out  3  constant 3'b000 (SINGLE)
- O_OWR_HWDATA  out  32  AHB write data
- I_OWR_HREADY  in  1  slave ready
- I_OWR_HRESP  in  1  1 = ERROR
- O_OWR_BUSY  out  1  high in ADDR/DATA
- O_OWR_DONE  out  1  one-cycle pulse at job end (normal or error)
- O_OWR_ERROR  out  1  sticky error flag, cleared on next accepted START

## Operation
- States: IDLE, ADDR, DATA, FIN, ERR.
- IDLE: START captures base/count; count==0 → FIN, else → ADDR. START in any other state ignored.
- ADDR: HTRANS=NONSEQ iff FIFO non-empty, else IDLE (wait). When NONSEQ && HREADY → DATA.
- DATA: HTRANS=IDLE; HWDATA = FIFO head (stable). On HREADY && !HRESP: pop FIFO, HADDR += 4 (mod 2^32, 0xFFFFFFFC wraps to 0), remaining -= 1; remaining reaches 0 → FIN else → ADDR. On HREADY && HRESP → ERR.
- FIN: DONE=1 one cycle → IDLE.
- ERR: ERROR set, FIFO flushed, DONE=1 one cycle → IDLE; remaining words abandoned.
- FIFO: push on WVALID && WREADY, independent of state (producer may prefill before START). WREADY = !full; a full FIFO popping this cycle does not accept a push the same cycle. Push and pop in same cycle when neither full nor empty: count unchanged. FIFO not cleared by START or FIN; only by reset and ERR (flush has priority over a same-cycle push; that word is dropped).
- Remaining counter 16 bits; decrement never below 0.

## Timing
- Reset (async assert, sync deassert by upstream): state IDLE, FIFO empty, HADDR=0, HTRANS=IDLE, HWDATA=0, WREADY=1, BUSY=0, DONE=0, ERROR=0. HWRITE/HSIZE/HBURST constants. Reset mid-job aborts immediately; no DONE.
- HTRANS, HWDATA decoded from registered state and FIFO head; HADDR registered.
- START at cycle 0 → ADDR at cycle 1; with FIFO non-empty and HREADY=1, NONSEQ at cycle 1, data phase cycle 2, next NONSEQ cycle 3: 2 cycles/word, N words → DONE at cycle 2N+1.
- Each HREADY-low cycle in ADDR or DATA adds one cycle; outputs held.
- Word written to FIFO at cycle k is first visible on HWDATA no earlier than k+1.

## Test plan
- Reset: assert HRESET mid-job with 3 words queued → all outputs at reset values next sample, WREADY=1, no DONE.
- Prefill 3 words 0x11223344, 0x55667788, 0x99AABBCC, START base 0x1000 count 3, HREADY=1 → NONSEQ at 0x1000/0x1004/0x1008 on cycles 1/3/5, matching HWDATA on 2/4/6, DONE cycle 7, ERROR=0.
- HREADY low 2 cycles in first data phase → HWDATA and HADDR held, DONE delayed by 2 cycles, data unchanged.
- FIFO_DEPTH=4, push 6 words continuously before START → WREADY drops after 4th, words 5–6 accepted only after pops; all 6 written in order with count 6.
- Base 0xFFFFFFF8 count 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- HRESP=1 on second data phase of count 4 → ERR, ERROR=1, DONE pulse, FIFO empty, no third NONSEQ; next START clears ERROR; count 0 START → DONE next cycle, no bus transfer.
